mmu_line_fill_buffer: RTL and testbench

- Sits downstream of the MMU datapath, on the pmem → icache path.
- Takes one line-fill request (line address) and issues a burst of sequential word reads to pmem, one word per response.
- Assembles the returned words into a full cache line, then presents that line to the icache over a valid/ready handshake.
- Holds one line at a time; it does not support overlapped fills.

---
 rtl/mmu_pkg.sv | 22 ++
 rtl/mmu_line_fill_buffer.sv | 101 ++++++++++
 tb/tb_mmu_line_fill_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared types and sizing helpers for the MMU-side line fill path.
// The localparams give the default geometry; modules call the helpers with their own parameters.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DELIVER = 2'd2
    } fill_state_t;

    function automatic int off_bits(input int words_per_line, input int word_w);
        return $clog2(words_per_line * word_w / 8);
    endfunction

    function automatic int cnt_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    localparam int OFF   = off_bits(8, 32);
    localparam int CNT_W = cnt_bits(8);

endpackage

// File: rtl/mmu_line_fill_buffer.sv
// Single-line fill buffer: bursts sequential word reads from pmem, assembles one cache line,
// and hands it to the icache. Handshakes: a transfer happens on a clock edge where valid and ready are both high.
module mmu_line_fill_buffer
    import mmu_pkg::*;
#(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_W-1:0]                req_addr,
    output logic                             pmem_read,
    output logic [ADDR_W-1:0]                pmem_addr,
    input  logic                             pmem_resp,
    input  logic [WORD_W-1:0]                pmem_rdata,
    output logic                             line_valid,
    input  logic                             line_ready,
    output logic [WORDS_PER_LINE*WORD_W-1:0] line_data,
    output logic [ADDR_W-1:0]                line_addr,
    output logic                             busy,
    output fill_state_t                      state
);

    localparam int LINE_OFF   = off_bits(WORDS_PER_LINE, WORD_W);
    localparam int LINE_CNT_W = cnt_bits(WORDS_PER_LINE);
    localparam int BYTE_SH    = $clog2(WORD_W / 8);

    localparam logic [ADDR_W-1:0]     LINE_MASK  = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));
    localparam logic [LINE_CNT_W-1:0] LAST_WORD  = LINE_CNT_W'(WORDS_PER_LINE - 1);

    logic [LINE_CNT_W-1:0]                     count;
    logic [ADDR_W-1:0]                         base;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]     line_buf;
    logic [ADDR_W-1:0]                         word_off;

    // base is line-aligned, so OR-ing in the word offset never carries out of the line.
    assign word_off  = ADDR_W'(count) << BYTE_SH;
    assign pmem_addr = (state == FILL) ? (base | word_off) : '0;
    assign line_data = line_buf;
    assign line_addr = base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            base       <= '0;
            line_buf   <= '0;
            req_ready  <= 1'b1;
            pmem_read  <= 1'b0;
            line_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base      <= req_addr & LINE_MASK;
                        count     <= '0;
                        state     <= FILL;
                        req_ready <= 1'b0;
                        pmem_read <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        line_buf[count] <= pmem_rdata;
                        if (count == LAST_WORD) begin
                            count      <= '0;
                            state      <= DELIVER;
                            pmem_read  <= 1'b0;
                            line_valid <= 1'b1;
                        end else begin
                            count <= count + LINE_CNT_W'(1);
                        end
                    end
                end
                DELIVER: begin
                    // Returning to IDLE guarantees one ready cycle before the next acceptance.
                    if (line_ready) begin
                        state      <= IDLE;
                        line_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    count      <= '0;
                    req_ready  <= 1'b1;
                    pmem_read  <= 1'b0;
                    line_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_line_fill_buffer.sv
// Bench for mmu_line_fill_buffer: table of directed fills plus randomized fills against a
// word-queue reference of the expected line, with hand-written reset and back-to-back sequences.
module tb_mmu_line_fill_buffer;
    import mmu_pkg::*;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int ADDR_W         = 32;
    localparam int LW             = WORDS_PER_LINE * WORD_W;
    localparam int LINE_BYTES     = LW / 8;
    localparam int WORD_BYTES     = WORD_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              pmem_read;
    logic [ADDR_W-1:0] pmem_addr;
    logic              pmem_resp;
    logic [WORD_W-1:0] pmem_rdata;
    logic              line_valid;
    logic              line_ready;
    logic [LW-1:0]     line_data;
    logic [ADDR_W-1:0] line_addr;
    logic              busy;
    fill_state_t       state;

    mmu_line_fill_buffer #(
        .WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .pmem_read(pmem_read), .pmem_addr(pmem_addr),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_addr(line_addr),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [LW-1:0]     exp_line;
    logic [ADDR_W-1:0] exp_addr;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                gap;
        int                bp;
        bit                hold;
        bit                fixed;
        logic [ADDR_W-1:0] base;
    } vec_t;

    vec_t vecs[6];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string name, input logic [LW-1:0] exp);
        checks++;
        if (line_data !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, line_data, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] model_base(input logic [ADDR_W-1:0] a);
        return (a / LINE_BYTES) * LINE_BYTES;
    endfunction

    // gap < 0 picks a random 0..2 idle cycles before each response.
    task automatic run_fill(input logic [ADDR_W-1:0] addr, input int gap, input bit hold,
                            input bit fixed, input logic [ADDR_W-1:0] base);
        logic [WORD_W-1:0] w;
        int g;
        chk1("idle_req_ready", req_ready, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        req_valid = 1'b1;
        req_addr  = addr;
        pmem_resp = 1'b0;
        step();
        req_valid = hold;
        req_addr  = $urandom;
        chk1("fill_busy", busy, 1'b1);
        chk1("fill_req_ready", req_ready, 1'b0);
        exp_q.delete();
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                pmem_resp  = 1'b0;
                pmem_rdata = $urandom;
                chk1("gap_pmem_read", pmem_read, 1'b1);
                chk32("gap_pmem_addr", pmem_addr, base + 32'(i * WORD_BYTES));
                step();
            end
            w = fixed ? WORD_W'(32'hA0 + i) : WORD_W'($urandom);
            pmem_resp  = 1'b1;
            pmem_rdata = w;
            exp_q.push_back(w);
            chk32("fill_pmem_addr", pmem_addr, base + 32'(i * WORD_BYTES));
            chk1("fill_pmem_read", pmem_read, 1'b1);
            chk1("fill_line_valid", line_valid, 1'b0);
            step();
        end
        pmem_resp = 1'b0;
        chk1("done_line_valid", line_valid, 1'b1);
        chk1("done_pmem_read", pmem_read, 1'b0);
        chk32("done_line_addr", line_addr, base);
        chk32("done_word_count", 32'(exp_q.size()), 32'(WORDS_PER_LINE));
        exp_line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) exp_line[i*WORD_W +: WORD_W] = exp_q.pop_front();
        exp_addr = base;
        chk_line("done_line_data", exp_line);
    endtask

    task automatic deliver(input int bp, input bit hold);
        for (int k = 0; k < bp; k++) begin
            line_ready = 1'b0;
            req_valid  = 1'b1;
            req_addr   = $urandom;
            pmem_resp  = 1'b1;
            pmem_rdata = $urandom;
            step();
            chk1("bp_line_valid", line_valid, 1'b1);
            chk1("bp_req_ready", req_ready, 1'b0);
            chk32("bp_line_addr", line_addr, exp_addr);
            chk_line("bp_line_data", exp_line);
        end
        line_ready = 1'b1;
        req_valid  = hold;
        pmem_resp  = 1'b0;
        step();
        line_ready = 1'b0;
        chk1("handoff_line_valid", line_valid, 1'b0);
        chk1("handoff_req_ready", req_ready, 1'b1);
        chk1("handoff_busy", busy, 1'b0);
        chk_line("handoff_line_data", exp_line);
        if (!hold) begin
            pmem_resp  = 1'b1;
            pmem_rdata = $urandom;
            step();
            pmem_resp = 1'b0;
            chk1("idle_resp_busy", busy, 1'b0);
            chk_line("idle_resp_line_data", exp_line);
        end
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_1234, gap: 0, bp: 0, hold: 1'b0, fixed: 1'b1, base: 32'h0000_1220};
        vecs[1] = '{addr: 32'h0000_1234, gap: 2, bp: 0, hold: 1'b0, fixed: 1'b1, base: 32'h0000_1220};
        vecs[2] = '{addr: 32'h0000_5678, gap: 0, bp: 5, hold: 1'b0, fixed: 1'b0, base: 32'h0000_5660};
        vecs[3] = '{addr: 32'hFFFF_FFFC, gap: 0, bp: 1, hold: 1'b0, fixed: 1'b0, base: 32'hFFFF_FFE0};
        vecs[4] = '{addr: 32'h0000_ABCD, gap: 1, bp: 0, hold: 1'b1, fixed: 1'b0, base: 32'h0000_ABC0};
        vecs[5] = '{addr: 32'h0000_0040, gap: -1, bp: 2, hold: 1'b0, fixed: 1'b0, base: 32'h0000_0040};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; pmem_resp = 1'b0;
        pmem_rdata = '0; line_ready = 1'b0;
        repeat (2) step();
        chk32("reset_state", 32'(state), 32'(IDLE));
        chk1("reset_req_ready", req_ready, 1'b1);
        chk1("reset_pmem_read", pmem_read, 1'b0);
        chk32("reset_pmem_addr", pmem_addr, 32'h0);
        chk1("reset_line_valid", line_valid, 1'b0);
        chk_line("reset_line_data", '0);
        chk32("reset_line_addr", line_addr, 32'h0);
        chk1("reset_busy", busy, 1'b0);
        #3 rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            run_fill(vecs[v].addr, vecs[v].gap, vecs[v].hold, vecs[v].fixed, vecs[v].base);
            deliver(vecs[v].bp, vecs[v].hold);
        end

        for (int r = 0; r < 8; r++) begin
            logic [ADDR_W-1:0] a;
            bit h;
            a = $urandom;
            h = (r < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_fill(a, -1, h, 1'b0, model_base(a));
            deliver(int'($urandom_range(0, 3)), h);
        end

        // Abort a fill after four responses with an asynchronous reset.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0300;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = $urandom | 32'h1;
            step();
        end
        pmem_resp = 1'b0;
        chk1("abort_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("abort_req_ready", req_ready, 1'b1);
        chk1("abort_pmem_read", pmem_read, 1'b0);
        chk32("abort_pmem_addr", pmem_addr, 32'h0);
        chk1("abort_line_valid", line_valid, 1'b0);
        chk_line("abort_line_data", '0);
        chk32("abort_line_addr", line_addr, 32'h0);
        chk1("abort_busy", busy, 1'b0);
        #2 rst = 1'b0;
        step();
        chk_line("post_abort_line_data", '0);
        run_fill(32'h0000_0040, 0, 1'b0, 1'b0, 32'h0000_0040);
        deliver(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
